// File: rtl/mem_bist.sv
// March-test initiator for a single-port memory: write P(a) up, read P / write ~P up, read ~P down.
// Registered memory-bus outputs; pass/fail, first failing address and a saturating error count.
module mem_bist #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_a,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [WIDTH-1:0] fail_addr,
  output logic [7:0]       err_count
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_A, S_WR_A, S_RD_D} state_t;

  localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_seed, w_seed;
  logic             r_we, w_we;
  logic [WIDTH-1:0] r_a, w_a;
  logic [WIDTH-1:0] r_wd, w_wd;
  logic             r_done, w_done;
  logic             r_fail, w_fail;
  logic [WIDTH-1:0] r_fail_addr, w_fail_addr;
  logic [7:0]       r_err, w_err;
  logic             w_chk;
  logic [WIDTH-1:0] w_pat, w_cmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_seed      <= '0;
      r_we        <= 1'b0;
      r_a         <= '0;
      r_wd        <= '0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_err       <= '0;
    end else begin
      r_state     <= w_state;
      r_seed      <= w_seed;
      r_we        <= w_we;
      r_a         <= w_a;
      r_wd        <= w_wd;
      r_done      <= w_done;
      r_fail      <= w_fail;
      r_fail_addr <= w_fail_addr;
      r_err       <= w_err;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_seed      = r_seed;
    w_we        = 1'b0;
    w_a         = r_a;
    w_wd        = r_wd;
    w_done      = r_done;
    w_fail      = r_fail;
    w_fail_addr = r_fail_addr;
    w_err       = r_err;
    w_chk       = 1'b0;
    w_pat       = r_a ^ r_seed;
    w_cmp       = w_pat;

    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_seed      = seed;
          w_done      = 1'b0;
          w_fail      = 1'b0;
          w_fail_addr = '0;
          w_err       = '0;
          w_state     = S_WR;
          w_a         = '0;
          w_we        = 1'b1;
          w_wd        = seed;
        end
      end
      S_WR: begin
        if (r_a == LAST) begin
          w_state = S_RD_A;
          w_a     = '0;
        end else begin
          w_a  = r_a + ONE;
          w_we = 1'b1;
          w_wd = (r_a + ONE) ^ r_seed;
        end
      end
      S_RD_A: begin
        w_chk   = 1'b1;
        w_state = S_WR_A;
        w_we    = 1'b1;
        w_wd    = ~w_pat;
      end
      S_WR_A: begin
        if (r_a == LAST) begin
          w_state = S_RD_D;
        end else begin
          w_state = S_RD_A;
          w_a     = r_a + ONE;
        end
      end
      S_RD_D: begin
        w_chk = 1'b1;
        w_cmp = ~w_pat;
        if (r_a == ZERO) begin
          w_state = S_IDLE;
          w_done  = 1'b1;
        end else begin
          w_a = r_a - ONE;
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Abort discards the current cycle's read and leaves done clear.
    if (abort && r_state != S_IDLE) begin
      w_state = S_IDLE;
      w_we    = 1'b0;
      w_a     = '0;
      w_chk   = 1'b0;
    end

    if (w_chk && (mem_rd != w_cmp)) begin
      if (!r_fail) begin
        w_fail      = 1'b1;
        w_fail_addr = r_a;
      end
      if (r_err != 8'hFF) w_err = r_err + 8'd1;
    end
  end

  assign mem_we    = r_we;
  assign mem_a     = r_a;
  assign mem_wd    = r_wd;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;
  assign err_count = r_err;

endmodule

// File: tb/tb_mem_bist.sv
// Directed bench for mem_bist: DEPTH=16 against a memory model with fault modes, DEPTH=256 for saturation.
module tb_mem_bist;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [7:0] seed;
  logic       mem_we;
  logic [7:0] mem_a, mem_wd, mem_rd;
  logic       busy, done, fail;
  logic [7:0] fail_addr, err_count;

  logic       b_start;
  logic       b_mem_we;
  logic [7:0] b_mem_a, b_mem_wd;
  logic [7:0] b_mem_rd;
  logic       b_busy, b_done, b_fail;
  logic [7:0] b_fail_addr, b_err_count;

  logic [7:0] mem [0:255];
  int         mode;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] tr_a  [0:255];
  logic       tr_we [0:255];

  always #5 clk = ~clk;

  mem_bist #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr), .err_count(err_count)
  );

  mem_bist #(.WIDTH(8), .DEPTH(256)) dut_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(1'b0), .seed(8'h00),
    .mem_we(b_mem_we), .mem_a(b_mem_a), .mem_wd(b_mem_wd), .mem_rd(b_mem_rd),
    .busy(b_busy), .done(b_done), .fail(b_fail), .fail_addr(b_fail_addr), .err_count(b_err_count)
  );

  assign b_mem_rd = 8'h00;

  always @(posedge clk) if (mem_we) mem[mem_a] <= mem_wd;

  always_comb begin
    mem_rd = mem[mem_a];
    if (mode == 1 && mem_a == 8'd5) mem_rd[0] = 1'b1;
    if (mode == 2) mem_rd = 8'hFF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one test, record the bus trace while busy; optionally poke start during the run.
  task automatic run(input logic [7:0] s, input bit poke, output int cyc);
    seed  = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
    while (busy && cyc < 200) begin
      tr_a[cyc]  = mem_a;
      tr_we[cyc] = mem_we;
      start      = poke && (cyc % 7 == 3);
      cyc++;
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    int cyc;
    int ok_mem;
    logic [7:0] ea;
    logic       ewe;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed = 8'h00; mode = 0; b_start = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_we", mem_we, 0);
    check("rst_outs", {done, fail, fail_addr, err_count, mem_a, mem_wd}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Good memory, seed 0; also the address/we trace
    run(8'h00, 1'b0, cyc);
    check("t1_cycles", cyc, 64);
    check("t1_done_fail", {done, fail, busy}, 3'b100);
    check("t1_err", err_count, 0);
    check("t1_faddr", fail_addr, 0);
    ok_mem = 1;
    for (int a = 0; a < 16; a++) begin
      ea = ~8'(a);
      if (mem[a] !== ea) ok_mem = 0;
    end
    check("t1_mem_final", ok_mem, 1);
    for (int k = 0; k < 64; k++) begin
      if (k < 16) begin
        ea = 8'(k); ewe = 1'b1;
      end else if (k < 48) begin
        ea = 8'((k - 16) / 2); ewe = ((k - 16) % 2) == 1;
      end else begin
        ea = 8'(63 - k); ewe = 1'b0;
      end
      check($sformatf("t6_a[%0d]", k), tr_a[k], ea);
      check($sformatf("t6_we[%0d]", k), tr_we[k], ewe);
    end

    // Bit0 stuck-at-1 at address 5, seed A5: only RD_A (expects A0) sees it
    mode = 1;
    run(8'hA5, 1'b0, cyc);
    check("t2_cycles", cyc, 64);
    check("t2_fail", fail, 1);
    check("t2_faddr", fail_addr, 5);
    check("t2_err", err_count, 1);
    check("t2_done", done, 1);

    // All reads FF; seed 5A keeps P(a) and ~P(a) away from FF for a<16
    mode = 2;
    run(8'h5A, 1'b0, cyc);
    check("t3_err", err_count, 32);
    check("t3_faddr", fail_addr, 0);
    check("t3_fail", fail, 1);
    mode = 0;

    // Saturation with DEPTH=256, reads 0, seed 0: 511 miscompares
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    cyc = 0;
    while (b_busy && cyc < 1100) begin
      cyc++;
      tick();
    end
    check("t3_big_cycles", cyc, 1024);
    check("t3_big_err", b_err_count, 255);
    check("t3_big_fail", {b_done, b_fail, b_fail_addr}, {2'b11, 8'd1});

    // start and abort together in IDLE: nothing starts
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("t4_start_abort", busy, 0);

    // Abort 10 cycles into WR
    seed = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("t4_in_wr", {busy, mem_we, mem_a}, {2'b11, 8'd10});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort", {busy, mem_we, done}, 3'b000);
    run(8'h00, 1'b0, cyc);
    check("t4_rerun_cycles", cyc, 64);
    check("t4_rerun_pass", {done, fail, err_count}, {2'b10, 8'd0});

    // start pulses while busy must not change the cycle count
    run(8'h3C, 1'b1, cyc);
    check("t5_poke_cycles", cyc, 64);
    check("t5_poke_pass", {done, fail}, 2'b10);

    // Reset in the RD_A/WR_A phase while a write is in flight
    seed = 8'h11; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    check("t5_pre_rst_we", {busy, mem_we}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_we", mem_we, 0);
    check("t5_rst_outs", {busy, done, fail, fail_addr, err_count, mem_a, mem_wd}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t5_after_rst_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
